// File: rtl/opl3_axil_pkg.sv
// Shared constants for the OPL3 AXI4-Lite register block.
//   NUM_REGS     number of 32-bit control registers exposed to the bus
//   REG_IDX_W    width of a register index (byte address bits [3:2])
//   RESP_*       AXI response codes
package opl3_axil_pkg;

    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/opl3_axil_regs.sv
// AXI4-Lite slave holding the four OPL3 control registers.
//   ACLK / ARESETN   clock, asynchronous active-low reset
//   S_AXI_AW*        write address channel (captured into its own slot)
//   S_AXI_W*         write data channel (captured into its own slot)
//   S_AXI_B*         write response, always OKAY
//   S_AXI_AR* / R*   read channel, one outstanding read, always OKAY
//   slv_reg          live register contents for the OPL3 core
//   reg_wr_pulse     one-hot strobe, high during the cycle a write commits
module opl3_axil_regs
    import opl3_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                          ACLK,
    input  logic                                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_AWADDR,
    input  logic [2:0]                                    S_AXI_AWPROT,
    input  logic                                          S_AXI_AWVALID,
    output logic                                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]               S_AXI_WSTRB,
    input  logic                                          S_AXI_WVALID,
    output logic                                          S_AXI_WREADY,
    output logic [1:0]                                    S_AXI_BRESP,
    output logic                                          S_AXI_BVALID,
    input  logic                                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_ARADDR,
    input  logic [2:0]                                    S_AXI_ARPROT,
    input  logic                                          S_AXI_ARVALID,
    output logic                                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_RDATA,
    output logic [1:0]                                    S_AXI_RRESP,
    output logic                                          S_AXI_RVALID,
    input  logic                                          S_AXI_RREADY,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]   slv_reg,
    output logic [NUM_REGS-1:0]                           reg_wr_pulse
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    // Held low through reset and raised on the first edge afterwards so the
    // READY outputs come up cleanly once the block is out of reset.
    logic                           ready_en;

    logic                           aw_full;
    reg_idx_t                       aw_idx;
    logic                           w_full;
    logic [C_S_AXI_DATA_WIDTH-1:0]  w_data;
    logic [STRB_W-1:0]              w_strb;
    logic                           bvalid;
    logic                           rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdata;

    logic                           b_stall;
    logic                           commit;
    logic                           aw_hs;
    logic                           w_hs;
    logic                           ar_hs;

    // A response still waiting for BREADY blocks both the commit of a new
    // write and the acceptance of its address/data.
    assign b_stall = bvalid & ~S_AXI_BREADY;
    assign commit  = aw_full & w_full & ~b_stall;

    assign S_AXI_AWREADY = ready_en & ~aw_full & ~b_stall;
    assign S_AXI_WREADY  = ready_en & ~w_full  & ~b_stall;
    assign S_AXI_ARREADY = ready_en & ~rvalid;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // Every address decodes, so no error response is ever produced.
    assign S_AXI_BRESP  = RESP_OKAY;
    assign S_AXI_RRESP  = RESP_OKAY;
    assign S_AXI_BVALID = bvalid;
    assign S_AXI_RVALID = rvalid;
    assign S_AXI_RDATA  = rdata;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // a path that skips the assignment would otherwise infer a latch.
        reg_wr_pulse = '0;
        if (commit) begin
            reg_wr_pulse[aw_idx] = 1'b1;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every flop
    // samples the values from before the edge; this is also what makes a
    // read in the commit cycle return the pre-write register value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en <= 1'b0;
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_idx  <= S_AXI_AWADDR[REG_IDX_W+1:2];
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_data <= S_AXI_WDATA;
                    w_strb <= S_AXI_WSTRB;
                end
            end
            if (commit) begin
                bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // NOTE: the register file is reset with everything else because the
    // OPL3 core reads it continuously and must see zeros, not X, after reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            slv_reg <= '0;
        end else if (commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) begin
                    slv_reg[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= slv_reg[S_AXI_ARADDR[REG_IDX_W+1:2]];
        end else if (S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    // Byte-offset bits, protection attributes and the error code are
    // intentionally unused.
    logic unused_bits;
    assign unused_bits = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           S_AXI_AWPROT, S_AXI_ARPROT, RESP_SLVERR};

endmodule
